serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
//   Complements the combinational 4-bit adder: subtraction instead of addition, sequential instead of parallel.
//   Sits beside the adder in the arithmetic datapath; a controller launches it with a start/ready handshake.
//   Overflow is reported as a flag (ovf); it is not signalled by tristating the result.
// PARAMETERS
//   WIDTH   4   operand/result width in bits, two's complement, WIDTH >= 2
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      launch request; accepted only when ready=1
//   a       in   WIDTH  minuend; sampled on the accepted-start cycle
//   b       in   WIDTH  subtrahend; sampled on the accepted-start cycle
//   ready   out  1      1 in IDLE and DONE; 0 in RUN
//   valid   out  1      1-cycle pulse; diff/ovf are final
//   diff    out  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start
//   ovf     out  1      signed overflow of a - b; held with diff
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, ready=1, valid=0, diff=0, ovf=0, internal regs=0.
//   Reset during RUN aborts the operation; no valid pulse is produced.
//   States:
//     IDLE: start=1 -> latch a into sa and ~b into sb; carry=1; bitcnt=0; go to RUN.
//     RUN:  each cycle, a single full_adder adds sa[0] + sb[0] + carry.
//           The sum bit shifts into the result MSB; sa and sb shift right; carry <= cout; bitcnt++.
//           After the WIDTH-th bit (bitcnt == WIDTH-1), go to DONE.
//           start is ignored; a and b may change freely.
//     DONE: valid=1 for exactly this cycle; diff and ovf update on entry.
//           start=1 -> relaunch exactly as from IDLE (back-to-back); otherwise go to IDLE.
//   Latency: start accepted at edge N; RUN occupies edges N+1..N+WIDTH; valid=1 in the cycle after edge N+WIDTH.
//   Throughput: one result per WIDTH+1 cycles when start is held high.
//   Overflow rule: ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands.
//     Keep a copy of a[MSB] and b[MSB]; the shift registers lose them.
//   On overflow, diff still holds the wrapped result.
//   Final carry-out is not exported.
//   bitcnt width = $clog2(WIDTH); no wrap issue, because it is reset on every launch.
//   Outputs are registered; there is no combinational path from inputs to outputs.
// STRUCTURE
//   Shared package arith_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH constant.
//   Sub-module: one instance of the existing full_adder (a, b, cin -> sum, cout); no other hierarchy.
//   Unused state encoding 2'd3 returns to IDLE.
// TESTING (WIDTH=4)
//   1. a=0101, b=0011, start 1 cycle -> ready=0 for 4 cycles; then valid=1, diff=0010, ovf=0.
//   2. a=0011, b=0101 -> diff=1110 (-2), ovf=0; a=1000, b=1000 -> diff=0000, ovf=0.
//   3. Overflow: a=0111, b=1111 -> diff=1000, ovf=1; a=1000, b=0001 -> diff=0111, ovf=1.
//   4. Start with a=0110, b=0001; then start=1 with a=0000, b=0000 during RUN
//      -> ignored; result diff=0101, valid pulses once.
//   5. Start held high continuously -> valid every 5 cycles; diff held between pulses.
//   6. rst=1 in the 2nd RUN cycle -> next cycle ready=1, diff=0, ovf=0; no valid pulse; a new start works normally.

Source files
------------

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the arithmetic datapath blocks.
//
//   Contents
//     ARITH_WIDTH    default operand/result width for the datapath
//     state_t        control state encoding of the bit-serial subtractor
//     sub_overflow   signed-overflow rule for a two's-complement subtraction
// -----------------------------------------------------------------------------
package arith_pkg;

    // Default operand width used by the datapath blocks.
    localparam int ARITH_WIDTH = 4;

    // Control states of the bit-serial subtractor. The encoding 2'd3 is
    // unused; the FSM returns to ST_IDLE if it ever lands there.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow of a - b. It can only happen when the operands have
    // different signs, and shows up as a result whose sign differs from the
    // minuend's sign.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic diff_msb
    );
        return (a_msb != b_msb) && (diff_msb != a_msb);
    endfunction

endpackage : arith_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder, shared with the parallel adder in the datapath.
//
//   Ports
//     a, b   in   1   addend bits
//     cin    in   1   carry in
//     sum    out  1   a ^ b ^ cin
//     cout   out  1   carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
//   LSB first. The subtraction is done as a + ~b + 1 with a single full adder;
//   the +1 comes from presetting the carry to 1 at launch.
//
//   A controller launches an operation with start while ready=1. The operands
//   are latched on that edge, WIDTH RUN cycles follow, and then valid pulses
//   for one cycle with the final diff/ovf. diff and ovf are held until the
//   next result replaces them. Holding start high relaunches straight from
//   DONE, giving one result every WIDTH+1 cycles.
//
//   Parameters
//     WIDTH   operand/result width, two's complement, WIDTH >= 2
//
//   Ports
//     clk     in   1      clock, rising edge
//     rst     in   1      synchronous, active-high reset
//     start   in   1      launch request, accepted only while ready=1
//     a       in   WIDTH  minuend, sampled on the accepted-start edge
//     b       in   WIDTH  subtrahend, sampled on the accepted-start edge
//     ready   out  1      1 in IDLE and DONE, 0 in RUN
//     valid   out  1      one-cycle pulse, diff/ovf are final
//     diff    out  WIDTH  a - b modulo 2^WIDTH
//     ovf     out  1      signed overflow of a - b
// -----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   sa;          // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0]   sb;          // inverted subtrahend, shifted likewise
    logic               carry;       // ripple carry between successive bits
    logic [CNT_W-1:0]   bitcnt;      // index of the bit being produced
    logic               a_msb;       // operand signs, kept for the overflow
    logic               b_msb;       // check after the shifters lose them

    // Partial result: the low WIDTH-1 bits, filled MSB-first so that the bit
    // produced in the last RUN cycle completes the word on its own.
    logic [WIDTH-2:0]   acc;

    logic               fa_sum;
    logic               fa_cout;
    logic               launch;
    logic               last_bit;
    logic [WIDTH-1:0]   result_full;

    // -------------------------------------------------------------------------
    // Bit slice
    // -------------------------------------------------------------------------
    full_adder u_full_adder (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // A start is accepted in IDLE and DONE alike; DONE relaunches back-to-back.
    assign launch      = ready & start;
    assign last_bit    = (state == ST_RUN) && (bitcnt == LAST_BIT);
    assign result_full = {fa_sum, acc};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, regardless of the order
    // in which the always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of a combinational block gives
    // every path a value, so no latch is inferred.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = (bitcnt == LAST_BIT) ? ST_DONE : ST_RUN;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only
    // -------------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: every datapath register, including the result, is cleared by
    // reset; a reset mid-operation must leave diff/ovf at zero, not at a stale
    // value from the aborted run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            acc    <= '0;
            diff   <= '0;
            ovf    <= 1'b0;
        end else if (launch) begin
            // a - b = a + ~b + 1: invert b here, inject the +1 as carry-in.
            sa     <= a;
            sb     <= ~b;
            carry  <= 1'b1;
            bitcnt <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            acc    <= '0;
        end else if (state == ST_RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            carry  <= fa_cout;
            bitcnt <= bitcnt + CNT_W'(1);
            acc    <= result_full[WIDTH-1:1];
            if (last_bit) begin
                // Result and flag are published together on entry to DONE.
                diff <= result_full;
                ovf  <= sub_overflow(a_msb, b_msb, fa_sum);
            end
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=4). A cycle-level
//   reference model computes ready/valid/diff/ovf from plain integer
//   arithmetic; a compare process checks the DUT against it on every falling
//   edge. Directed operations additionally check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         valid;
    logic [W-1:0] diff;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .valid (valid),
        .diff  (diff),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: an operation is "busy" for W cycles after acceptance,
    // then publishes (a - b) mod 2^W and the signed-range overflow.
    // ------------------------------------------------------------------------
    function automatic int to_signed(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    function automatic bit ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int d;
        d = to_signed(x) - to_signed(y);
        return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
    endfunction

    bit           m_ready  = 1'b1;
    bit           m_valid  = 1'b0;
    logic [W-1:0] m_diff   = '0;
    bit           m_ovf    = 1'b0;
    int           m_busy   = 0;
    logic [W-1:0] m_pend_d = '0;
    bit           m_pend_o = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 0;
            m_valid = 1'b0;
            m_diff  = '0;
            m_ovf   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_busy == 0) begin
                if (start) begin
                    m_pend_d = a - b;
                    m_pend_o = ref_ovf(a, b);
                    m_busy   = W;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_diff  = m_pend_d;
                    m_ovf   = m_pend_o;
                    m_valid = 1'b1;
                end
            end
        end
        m_ready = (m_busy == 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", ready, m_ready);
            check("model_valid", valid, m_valid);
            check("model_diff",  diff,  m_diff);
            check("model_ovf",   ovf,   m_ovf);
        end
    end

    // ------------------------------------------------------------------------
    // Directed operation: launch from a ready state, count busy cycles, wait
    // (bounded) for valid, and check literal results.
    // ------------------------------------------------------------------------
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] exp_d, input bit exp_o, input string nm);
        int busy;
        bit seen;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            if (!ready) busy++;
            @(negedge clk);
        end
        check({nm, "_valid_seen"}, seen, 1);
        check({nm, "_busy_cycles"}, busy, W);
        check({nm, "_diff"}, diff, exp_d);
        check({nm, "_ovf"},  ovf,  exp_o);
        check({nm, "_model_diff"}, m_diff, exp_d);
        check({nm, "_model_ovf"},  m_ovf,  exp_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int last;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_ready", ready, 1);
        check("reset_valid", valid, 0);
        check("reset_diff",  diff,  0);
        check("reset_ovf",   ovf,   0);
        rst = 1'b0;

        // Basic, negative result, equal operands.
        do_op(4'b0101, 4'b0011, 4'b0010, 1'b0, "t1_5m3");
        do_op(4'b0011, 4'b0101, 4'b1110, 1'b0, "t2_3m5");
        do_op(4'b1000, 4'b1000, 4'b0000, 1'b0, "t2_8m8");

        // Overflow in both directions; diff keeps the wrapped value.
        do_op(4'b0111, 4'b1111, 4'b1000, 1'b1, "t3_7mm1");
        do_op(4'b1000, 4'b0001, 4'b0111, 1'b1, "t3_m8m1");

        // start during RUN is ignored; exactly one valid pulse.
        @(negedge clk);
        a = 4'b0110; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        a = 4'b0000; b = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (valid) begin
                pulses++;
                check("t4_diff", diff, 4'b0101);
                check("t4_ovf",  ovf,  0);
            end
            @(negedge clk);
        end
        check("t4_valid_pulses", pulses, 1);

        // start held high: one result every W+1 cycles.
        a = 4'($urandom); b = 4'($urandom); start = 1'b1;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 6 * (W + 1); i++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (last >= 0) check("t5_period", i - last, W + 1);
                last = i;
            end
            a = 4'($urandom); b = 4'($urandom);
        end
        check("t5_pulse_count_min", pulses >= 5, 1);
        start = 1'b0;
        repeat (2 * W) @(negedge clk);

        // Reset in the 2nd RUN cycle aborts without a valid pulse.
        a = 4'b0011; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_ready", ready, 1);
        check("t6_diff",  diff,  0);
        check("t6_ovf",   ovf,   0);
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (valid) pulses++;
            @(negedge clk);
        end
        check("t6_no_valid", pulses, 0);
        do_op(4'b0100, 4'b0110, 4'b1110, 1'b0, "t6_after");

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a     = 4'($urandom);
            b     = 4'($urandom);
            rst   = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (2 * W + 2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
